// File: rtl/serial_paralelo_rx_pkg.sv
// ---------------------------------------------------------------------------
// serial_paralelo_rx_pkg
// Constants and types shared by the serial receiver and the matching tx
// serializer: the default comma/idle symbol, the link state encoding and
// the counter widths.
// ---------------------------------------------------------------------------
package serial_paralelo_rx_pkg;

  // Idle symbol the transmitter emits while it has no valid data.
  localparam logic [7:0] COM_DEFAULT = 8'hBC;

  // Bit position within a byte slot (0..7).
  localparam int BIT_CNT_W = 3;

  // Count of consecutive aligned commas seen while aligning.
  localparam int BC_CNT_W = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } link_state_t;

endpackage

// File: rtl/serial_paralelo_rx_com_detector.sv
// ---------------------------------------------------------------------------
// com_detector
// 8-bit left-shifting deserializer with a comma comparator. The byte that
// completes on this cycle (including the bit currently on data_i) is exposed
// combinationally so the receiver can act on it at the same edge that
// samples its last bit.
//
// Ports:
//   clk_i      bit-rate clock
//   rst_ni     synchronous active-low reset
//   data_i     serial input, MSB first
//   sr_next_o  byte formed by the last 7 stored bits plus data_i
//   is_com_o   sr_next_o equals the comma symbol
// ---------------------------------------------------------------------------
module com_detector
  import serial_paralelo_rx_pkg::*;
#(
  parameter logic [7:0] COM = COM_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       data_i,
  output logic [7:0] sr_next_o,
  output logic       is_com_o
);

  logic [7:0] sr_q;

  assign sr_next_o = {sr_q[6:0], data_i};
  assign is_com_o  = (sr_next_o == COM);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_q <= 8'h00;
    end else begin
      sr_q <= sr_next_o;
    end
  end

endmodule

// File: rtl/serial_paralelo_rx.sv
// ---------------------------------------------------------------------------
// serial_paralelo_rx
// Serial-to-parallel receiver. Hunts bit by bit for the comma symbol, then
// requires BC_COUNT consecutive byte-aligned commas before declaring the
// link active. Once active, every byte slot produces a strobe; non-comma
// bytes are presented on data_out with valid_out set, comma bytes clear
// valid_out and leave data_out unchanged. The link stays active until reset.
//
// Ports:
//   clk_32f      bit-rate clock, all logic on rising edge
//   reset        synchronous active-low reset
//   data_in      serial bit stream, MSB first
//   data_out     last received non-comma byte
//   valid_out    data_out was received in the most recent byte slot
//   byte_strobe  one-cycle pulse per completed aligned byte (ACTIVE only)
//   active       alignment achieved
// ---------------------------------------------------------------------------
module serial_paralelo_rx
  import serial_paralelo_rx_pkg::*;
#(
  parameter logic [7:0] COM      = COM_DEFAULT,
  parameter int         BC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  logic [7:0] sr_next;
  logic       is_com;

  com_detector #(
    .COM (COM)
  ) u_com_detector (
    .clk_i     (clk_32f),
    .rst_ni    (reset),
    .data_i    (data_in),
    .sr_next_o (sr_next),
    .is_com_o  (is_com)
  );

  link_state_t          state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BC_CNT_W-1:0]  bc_cnt_q, bc_cnt_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 strobe_q, strobe_d;
  logic                 active_q, active_d;

  logic                 boundary;
  logic [BC_CNT_W-1:0]  bc_inc;

  // The last bit of an aligned byte arrives when the slot counter reads 7.
  assign boundary = (bit_cnt_q == BIT_CNT_W'(7));
  assign bc_inc   = bc_cnt_q + BC_CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;

    case (state_q)
      SEARCH: begin
        // Bit-granular hunt: any bit offset may start an aligned byte.
        bit_cnt_d = '0;
        if (is_com) begin
          state_d  = ALIGN;
          bc_cnt_d = BC_CNT_W'(1);
        end
      end

      ALIGN: begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        if (boundary) begin
          if (is_com) begin
            bc_cnt_d = bc_inc;
            if (bc_inc == BC_CNT_W'(BC_COUNT)) begin
              // The locking comma itself produces no strobe.
              state_d = ACTIVE;
            end
          end else begin
            state_d  = SEARCH;
            bc_cnt_d = '0;
          end
        end
      end

      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        if (boundary) begin
          strobe_d = 1'b1;
          if (!is_com) begin
            data_d  = sr_next;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d  = SEARCH;
        bc_cnt_d = '0;
      end
    endcase

    active_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q   <= SEARCH;
      bit_cnt_q <= '0;
      bc_cnt_q  <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      active_q  <= active_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_paralelo_rx
// Scoreboard bench. Each stimulus stream is a plain bit array; a reference
// model scans that array for the lock point and derives the list of byte
// events (cycle, data, valid) that must follow. A monitor compares the DUT
// every cycle against the scoreboard.
// ---------------------------------------------------------------------------
module tb_serial_paralelo_rx;

  localparam logic [7:0] COM      = 8'hBC;
  localparam int         BC_COUNT = 4;

  logic       clk;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  serial_paralelo_rx #(
    .COM      (COM),
    .BC_COUNT (BC_COUNT)
  ) dut (
    .clk_32f     (clk),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       v;
  } ev_t;

  int         checks   = 0;
  int         failures = 0;
  bit         stim[$];
  ev_t        exp_q[$];
  int         lock_edge;
  int         last_edge;
  bit         running  = 1'b0;
  logic [7:0] exp_data;
  logic       exp_valid;
  string      cur_test;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s at edge %0d: got 0x%0h expected 0x%0h",
               cur_test, name, last_edge, act, exp);
    end
  endtask

  // Byte window ending at bit index i; bits before the stream are the
  // zeros left in the shift register by reset.
  function automatic logic [7:0] win(int i);
    logic [7:0] w;
    w = 8'h00;
    for (int t = 0; t < 8; t++) begin
      int idx;
      idx = i - 7 + t;
      w = {w[6:0], (idx >= 0) ? stim[idx] : 1'b0};
    end
    return w;
  endfunction

  // Bit index at which the link locks, or -1 if it never does.
  function automatic int find_lock();
    int n;
    int i;
    n = stim.size();
    i = 0;
    while (i < n) begin
      if (win(i) == COM) begin
        bit ok;
        int fail_at;
        ok = 1'b1;
        fail_at = 0;
        for (int k = 1; k < BC_COUNT; k++) begin
          if (i + 8 * k >= n) return -1;
          if (ok && win(i + 8 * k) != COM) begin
            ok = 1'b0;
            fail_at = i + 8 * k;
            break;
          end
        end
        if (ok) return i + 8 * (BC_COUNT - 1);
        i = fail_at + 1;
      end else begin
        i++;
      end
    end
    return -1;
  endfunction

  task automatic push_byte(logic [7:0] b);
    for (int t = 7; t >= 0; t--) stim.push_back(b[t]);
  endtask

  task automatic push_junk(int nbits);
    for (int t = 0; t < nbits; t++) stim.push_back(1'($urandom));
  endtask

  // Reset, then play stim[] one bit per cycle against the scoreboard.
  task automatic run_stream(string name);
    logic [7:0] prev;
    cur_test = name;
    exp_q.delete();
    lock_edge = find_lock();
    prev = 8'h00;
    if (lock_edge >= 0) begin
      for (int e = lock_edge + 8; e < stim.size(); e += 8) begin
        logic [7:0] b;
        b = win(e);
        if (b != COM) begin
          exp_q.push_back('{cyc: e, d: b, v: 1'b1});
          prev = b;
        end else begin
          exp_q.push_back('{cyc: e, d: prev, v: 1'b0});
        end
      end
    end

    running   = 1'b0;
    last_edge = -1;
    reset     = 1'b0;
    for (int r = 0; r < 3; r++) begin
      data_in = 1'($urandom);
      @(posedge clk);
      #1;
      chk("rst_data_out", 32'(data_out), 32'h0);
      chk("rst_valid_out", 32'(valid_out), 32'h0);
      chk("rst_byte_strobe", 32'(byte_strobe), 32'h0);
      chk("rst_active", 32'(active), 32'h0);
    end
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    reset     = 1'b1;
    for (int k = 0; k < stim.size(); k++) begin
      data_in = stim[k];
      @(posedge clk);
      #1;
      last_edge = k;
      running   = 1'b1;
    end
    @(negedge clk);
    #1;
    running = 1'b0;
    chk("events_left", 32'(exp_q.size()), 32'h0);
    $display("stream %s: bits=%0d lock_edge=%0d data_out=0x%02h valid_out=%0b active=%0b",
             name, stim.size(), lock_edge, data_out, valid_out, active);
  endtask

  // Monitor: compares every cycle of a running stream.
  always @(negedge clk) begin
    if (running) begin
      logic exp_act;
      logic exp_strobe;
      exp_act    = (lock_edge >= 0) && (last_edge >= lock_edge);
      exp_strobe = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc == last_edge) begin
        ev_t ev;
        ev = exp_q.pop_front();
        exp_strobe = 1'b1;
        exp_data   = ev.d;
        exp_valid  = ev.v;
      end
      chk("active", 32'(active), 32'(exp_act));
      chk("byte_strobe", 32'(byte_strobe), 32'(exp_strobe));
      chk("data_out", 32'(data_out), 32'(exp_data));
      chk("valid_out", 32'(valid_out), 32'(exp_valid));
      if (byte_strobe)
        $display("  edge %0d: byte 0x%02h valid=%0b", last_edge, data_out, valid_out);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    data_in = 1'b0;
    cur_test = "init";
    last_edge = -1;
    lock_edge = -1;
    exp_data  = 8'h00;
    exp_valid = 1'b0;

    // Junk bits, four commas, then a data byte.
    stim.delete();
    stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1);
    for (int i = 0; i < 4; i++) push_byte(COM);
    push_byte(8'hA5);
    run_stream("lock_a5");
    chk("final_a5_data", 32'(data_out), 32'hA5);
    chk("final_a5_valid", 32'(valid_out), 32'h1);

    // A comma between data bytes holds data_out and clears valid_out.
    stim.delete();
    for (int i = 0; i < 4; i++) push_byte(COM);
    push_byte(8'h3C); push_byte(COM); push_byte(8'h7E);
    run_stream("hold_on_com");
    chk("final_7e_data", 32'(data_out), 32'h7E);
    chk("final_7e_valid", 32'(valid_out), 32'h1);

    // Broken comma run falls back to search; lock only after 4 fresh commas.
    stim.delete();
    push_byte(COM); push_byte(COM); push_byte(8'h55);
    for (int i = 0; i < 4; i++) push_byte(COM);
    run_stream("broken_align");
    chk("final_broken_active", 32'(active), 32'h1);

    // Locked link cut mid-byte; the next stream starts with a reset.
    stim.delete();
    for (int i = 0; i < 4; i++) push_byte(COM);
    push_byte(8'h3C);
    stim.push_back(1'b1); stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1);
    run_stream("cut_mid_byte");

    // After reset three commas are not enough; four fresh ones are.
    stim.delete();
    for (int i = 0; i < 3; i++) push_byte(COM);
    push_byte(8'h11);
    for (int i = 0; i < 4; i++) push_byte(COM);
    push_byte(8'h22);
    run_stream("relock");
    chk("final_relock_data", 32'(data_out), 32'h22);

    // Full byte sweep after lock.
    stim.delete();
    push_junk(5);
    for (int i = 0; i < 4; i++) push_byte(COM);
    for (int b = 0; b < 256; b++) push_byte(8'(b));
    run_stream("sweep");

    // Randomized streams: junk, comma runs with occasional breaks, data.
    for (int it = 0; it < 8; it++) begin
      int nb;
      stim.delete();
      push_junk($urandom_range(0, 20));
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) push_byte(COM);
      if ($urandom_range(0, 2) == 0) begin
        push_byte(8'($urandom));
        for (int i = 0; i < 4; i++) push_byte(COM);
      end
      for (int i = 0; i < 12; i++) begin
        if ($urandom_range(0, 4) == 0) push_byte(COM);
        else push_byte(8'($urandom));
      end
      run_stream($sformatf("random_%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
